// File: rtl/regfile_write_scheduler.sv
// Round-robin arbiter sharing the register file write port between two writeback
// sources, with a one-bit-per-register pending-write scoreboard for decode stalls.
module regfile_write_scheduler #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREG   = 32
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_reg,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_reg,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_reg,
   input  logic [ADDR_W-1:0] rd1_reg,
   input  logic [ADDR_W-1:0] rd2_reg,
   output logic              rd1_busy,
   output logic              rd2_busy,
   output logic              regWen,
   output logic [ADDR_W-1:0] writeReg,
   output logic [DATA_W-1:0] writeData,
   output logic [NREG-1:0]   busy_vec,
   output logic              err_unrsv
);

   logic              lg_reg;
   logic              gnt0;
   logic              gnt1;
   logic              gnt_any;
   logic              gnt_nz;
   logic [ADDR_W-1:0] gnt_reg;
   logic [DATA_W-1:0] gnt_data;
   logic [NREG-1:0]   busy_reg;
   logic [NREG-1:0]   busy_next;
   logic              regwen_reg;
   logic [ADDR_W-1:0] writereg_reg;
   logic [DATA_W-1:0] writedata_reg;
   logic              err_reg;
   logic              err_next;

   // lg_reg=1 means requester 1 won last, so requester 0 has priority on a tie
   assign gnt0     = req0_valid && (!req1_valid || lg_reg);
   assign gnt1     = req1_valid && (!req0_valid || !lg_reg);
   assign gnt_any  = gnt0 || gnt1;
   assign gnt_reg  = gnt1 ? req1_reg : req0_reg;
   assign gnt_data = gnt1 ? req1_data : req0_data;
   assign gnt_nz   = gnt_any && (gnt_reg != '0);

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // A write granted this cycle is still in flight, so it must stall readers too
   assign rd1_busy = busy_reg[rd1_reg] || (gnt_nz && (gnt_reg == rd1_reg));
   assign rd2_busy = busy_reg[rd2_reg] || (gnt_nz && (gnt_reg == rd2_reg));

   assign err_next = gnt_nz && !busy_reg[gnt_reg];

   assign busy_next[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < NREG; gi++) begin : g_busy
         // Reserve beats clear: a newer producer is outstanding for this register
         assign busy_next[gi] = (rsv_en && (rsv_reg == ADDR_W'(gi)))
                             || (busy_reg[gi] && !(gnt_any && (gnt_reg == ADDR_W'(gi))));
      end
   endgenerate

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         lg_reg        <= 1'b1;
         busy_reg      <= '0;
         regwen_reg    <= 1'b0;
         writereg_reg  <= '0;
         writedata_reg <= '0;
         err_reg       <= 1'b0;
      end else begin
         if (gnt_any) begin
            lg_reg        <= gnt1;
            writereg_reg  <= gnt_reg;
            writedata_reg <= gnt_data;
         end
         regwen_reg <= gnt_nz;
         busy_reg   <= busy_next;
         if (err_next) begin
            err_reg <= 1'b1;
         end
      end
   end

   assign regWen    = regwen_reg;
   assign writeReg  = writereg_reg;
   assign writeData = writedata_reg;
   assign busy_vec  = busy_reg;
   assign err_unrsv = err_reg;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed and randomized bench for regfile_write_scheduler; a negedge reference model
// checks every output each cycle, and directed steps pin literal expectations.
module tb_regfile_write_scheduler;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic [4:0]  req0_reg, req1_reg;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic        rsv_en;
   logic [4:0]  rsv_reg, rd1_reg, rd2_reg;
   logic        rd1_busy, rd2_busy;
   logic        reg_wen;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [31:0] busy_vec;
   logic        err_unrsv;

   int nchk = 0;
   int nerr = 0;

   regfile_write_scheduler #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
      .Clk(clk), .Rst(rst_n),
      .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
      .rsv_en(rsv_en), .rsv_reg(rsv_reg), .rd1_reg(rd1_reg), .rd2_reg(rd2_reg),
      .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
      .regWen(reg_wen), .writeReg(write_reg), .writeData(write_data),
      .busy_vec(busy_vec), .err_unrsv(err_unrsv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: state as seen after the most recent posedge
   int          m_last;
   logic [31:0] m_busy;
   logic        m_err, m_wen;
   logic [4:0]  m_wreg;
   logic [31:0] m_wdata;

   always @(negedge clk) begin
      int          winner;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      if (!rst_n) begin
         m_last = 1; m_busy = '0; m_err = 1'b0; m_wen = 1'b0; m_wreg = '0; m_wdata = '0;
      end
      winner = -1;
      if (req0_valid && req1_valid) winner = 1 - m_last;
      else if (req0_valid)          winner = 0;
      else if (req1_valid)          winner = 1;
      wreg  = (winner == 1) ? req1_reg  : req0_reg;
      wdata = (winner == 1) ? req1_data : req0_data;
      cmp("m_ready0", 32'(req0_ready), 32'(winner == 0));
      cmp("m_ready1", 32'(req1_ready), 32'(winner == 1));
      cmp("m_rd1_busy", 32'(rd1_busy), 32'(m_busy[rd1_reg] || (winner >= 0 && wreg == rd1_reg && rd1_reg != 0)));
      cmp("m_rd2_busy", 32'(rd2_busy), 32'(m_busy[rd2_reg] || (winner >= 0 && wreg == rd2_reg && rd2_reg != 0)));
      cmp("m_regWen", 32'(reg_wen), 32'(m_wen));
      cmp("m_writeReg", 32'(write_reg), 32'(m_wreg));
      cmp("m_writeData", write_data, m_wdata);
      cmp("m_busy_vec", busy_vec, m_busy);
      cmp("m_err_unrsv", 32'(err_unrsv), 32'(m_err));
      if (rst_n) begin
         if (winner >= 0) begin
            $display("grant req%0d reg=%0d data=%h", winner, wreg, wdata);
            m_last  = winner;
            m_wen   = (wreg != 0);
            m_wreg  = wreg;
            m_wdata = wdata;
            if (wreg != 0 && !m_busy[wreg]) m_err = 1'b1;
            if (wreg != 0) m_busy[wreg] = 1'b0;
         end else begin
            m_wen = 1'b0;
         end
         if (rsv_en && rsv_reg != 0) m_busy[rsv_reg] = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req0_valid = 1'b0; req1_valid = 1'b0; rsv_en = 1'b0;
   endtask

   task automatic reserve(input logic [4:0] r);
      rsv_en = 1'b1; rsv_reg = r;
   endtask

   initial begin
      logic g0, g1;
      rst_n = 1'b0;
      req0_valid = 0; req0_reg = 0; req0_data = 0;
      req1_valid = 0; req1_reg = 0; req1_data = 0;
      rsv_en = 0; rsv_reg = 0; rd1_reg = 0; rd2_reg = 0;
      tick(); tick();
      cmp("reset_regWen", 32'(reg_wen), 32'd0);
      cmp("reset_busy_vec", busy_vec, 32'd0);
      rst_n = 1'b1;

      // single write r5
      tick(); reserve(5'd5);
      tick(); idle();
      req0_valid = 1; req0_reg = 5; req0_data = 32'hDEADBEEF;
      #1 cmp("single_ready0", 32'(req0_ready), 32'd1);
      tick(); idle();
      cmp("single_regWen", 32'(reg_wen), 32'd1);
      cmp("single_writeReg", 32'(write_reg), 32'd5);
      cmp("single_writeData", write_data, 32'hDEADBEEF);
      tick();
      cmp("idle_regWen", 32'(reg_wen), 32'd0);

      // scoreboard round trip on r7
      reserve(5'd7);
      tick(); idle(); rd1_reg = 7;
      #1 cmp("sb_rd1_busy_rsv", 32'(rd1_busy), 32'd1);
      tick();
      req1_valid = 1; req1_reg = 7; req1_data = 32'h0000_0777;
      #1 cmp("sb_ready1", 32'(req1_ready), 32'd1);
      cmp("sb_rd1_busy_grant", 32'(rd1_busy), 32'd1);
      tick(); idle();
      #1 cmp("sb_rd1_busy_after", 32'(rd1_busy), 32'd0);
      cmp("sb_busy7", 32'(busy_vec[7]), 32'd0);

      // reserve/clear collision on r9
      reserve(5'd9);
      tick();
      reserve(5'd9);
      req0_valid = 1; req0_reg = 9; req0_data = 32'h99;
      tick(); idle();
      cmp("coll_busy9", 32'(busy_vec[9]), 32'd1);
      cmp("coll_regWen", 32'(reg_wen), 32'd1);
      cmp("coll_writeReg", 32'(write_reg), 32'd9);
      cmp("coll_err", 32'(err_unrsv), 32'd0);
      req1_valid = 1; req1_reg = 9; req1_data = 32'h999;
      tick(); idle();

      // r0 write is handshaken and dropped
      req0_valid = 1; req0_reg = 0; req0_data = 32'h1234;
      #1 cmp("r0_ready0", 32'(req0_ready), 32'd1);
      tick(); idle();
      cmp("r0_regWen", 32'(reg_wen), 32'd0);
      cmp("r0_busy_vec", busy_vec, 32'd0);
      cmp("r0_err", 32'(err_unrsv), 32'd0);

      // unreserved write to r3
      req1_valid = 1; req1_reg = 3; req1_data = 32'h33;
      tick(); idle();
      cmp("unrsv_regWen", 32'(reg_wen), 32'd1);
      cmp("unrsv_err", 32'(err_unrsv), 32'd1);
      tick(); tick();
      cmp("unrsv_err_sticky", 32'(err_unrsv), 32'd1);

      // both valid for 4 cycles; last grant was req1 so req0 goes first
      for (int k = 0; k < 4; k++) begin
         req0_valid = 1; req0_reg = 1; req0_data = 32'hA;
         req1_valid = 1; req1_reg = 2; req1_data = 32'hB;
         #1 cmp("rr_ready0", 32'(req0_ready), 32'((k % 2) == 0));
         cmp("rr_ready1", 32'(req1_ready), 32'((k % 2) == 1));
         tick();
         cmp("rr_regWen", 32'(reg_wen), 32'd1);
         cmp("rr_writeReg", 32'(write_reg), (k % 2 == 0) ? 32'd1 : 32'd2);
      end
      idle();

      // reset mid-stream with busy_vec=0xF0 and regWen=1
      reserve(5'd4); tick();
      reserve(5'd5); tick();
      reserve(5'd6); tick();
      reserve(5'd7);
      req0_valid = 1; req0_reg = 8; req0_data = 32'h88;
      tick(); idle();
      cmp("pre_rst_busy_vec", busy_vec, 32'h0000_00F0);
      cmp("pre_rst_regWen", 32'(reg_wen), 32'd1);
      #1 rst_n = 1'b0;
      req0_valid = 1; req0_reg = 10; req0_data = 32'hC0;
      req1_valid = 1; req1_reg = 11; req1_data = 32'hC1;
      #1 cmp("rst_regWen", 32'(reg_wen), 32'd0);
      cmp("rst_writeReg", 32'(write_reg), 32'd0);
      cmp("rst_writeData", write_data, 32'd0);
      cmp("rst_busy_vec", busy_vec, 32'd0);
      cmp("rst_err", 32'(err_unrsv), 32'd0);
      cmp("rst_ready0", 32'(req0_ready), 32'd1);
      cmp("rst_ready1", 32'(req1_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      #1 cmp("post_rst_ready0", 32'(req0_ready), 32'd1);
      tick();
      cmp("post_rst_writeReg", 32'(write_reg), 32'd10);
      idle();
      tick();

      // randomized traffic, holding reg/data while a request waits
      g0 = 1'b0; g1 = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!(req0_valid && !g0)) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_reg   = 5'($urandom_range(0, 15));
            req0_data  = $urandom;
         end
         if (!(req1_valid && !g1)) begin
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_reg   = 5'($urandom_range(0, 15));
            req1_data  = $urandom;
         end
         rsv_en  = ($urandom_range(0, 1) != 0);
         rsv_reg = 5'($urandom_range(0, 15));
         rd1_reg = 5'($urandom_range(0, 15));
         rd2_reg = 5'($urandom_range(0, 15));
         #2;
         g0 = req0_ready;
         g1 = req1_ready;
         tick();
      end
      idle();
      tick(); tick();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
